psum_drain: RTL

- Collects the skewed partial sums that leave the bottom row of the systolic MAC array. Column j's result for a given output row arrives j cycles after column 0's result.
- De-skews the N_COLS columns into one aligned row.
- Requantizes each lane from the P format to the A format with rounding and saturation.
- Buffers rows in a FIFO and presents them on a valid/ready stream for write-back to the activation buffer.

---
 rtl/psum_drain.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/psum_drain.sv
// De-skews the bottom-row partial sums of the systolic array, requantizes each lane
// from the P to the A fixed-point format and queues aligned rows on a valid/ready stream.
module psum_drain #(
  parameter int unsigned N_COLS     = 4,
  parameter int unsigned P_BITWIDTH = 40,
  parameter int unsigned P_FRAC_BIT = 14,
  parameter int unsigned A_BITWIDTH = 16,
  parameter int unsigned A_FRAC_BIT = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  input  logic [N_COLS*P_BITWIDTH-1:0]     p_i,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [N_COLS*A_BITWIDTH-1:0]     out_data,
  output logic [$clog2(FIFO_DEPTH):0]      fifo_count,
  output logic                             ovf,
  input  logic                             ovf_clr
);

  localparam int unsigned Sh   = P_FRAC_BIT - A_FRAC_BIT;
  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned RowW = N_COLS * A_BITWIDTH;

  if (N_COLS < 2) begin : g_bad_cols
    $error("psum_drain: N_COLS must be at least 2");
  end
  if (P_FRAC_BIT <= A_FRAC_BIT) begin : g_bad_frac
    $error("psum_drain: P_FRAC_BIT must exceed A_FRAC_BIT");
  end
  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("psum_drain: FIFO_DEPTH must be a power of 2 and at least 2");
  end

  // ---------------------------------------------------------------------------
  // Skew tracking: vd[j] is in_valid delayed by j cycles, i.e. lane j is live.
  // ---------------------------------------------------------------------------
  logic [N_COLS-1:0] vd;
  logic [N_COLS-1:1] vld_q;

  assign vd = {vld_q, in_valid};

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
    end else begin
      vld_q <= vd[N_COLS-2:0];
    end
  end

  // ---------------------------------------------------------------------------
  // De-skew: lane j rides N_COLS-1-j registers; each stage only moves when the
  // row it belongs to is passing, so idle lanes do not toggle.
  // ---------------------------------------------------------------------------
  logic [P_BITWIDTH-1:0] lane_al [N_COLS];

  for (genvar j = 0; j < N_COLS - 1; j++) begin : g_lane
    localparam int Stages = N_COLS - 1 - j;
    logic [P_BITWIDTH-1:0] stg_q [Stages];

    always_ff @(posedge clk) begin
      if (vd[j]) begin
        stg_q[0] <= p_i[j*P_BITWIDTH +: P_BITWIDTH];
      end
      for (int k = 1; k < Stages; k++) begin
        if (vd[j+k]) begin
          stg_q[k] <= stg_q[k-1];
        end
      end
    end

    assign lane_al[j] = stg_q[Stages-1];
  end

  assign lane_al[N_COLS-1] = p_i[(N_COLS-1)*P_BITWIDTH +: P_BITWIDTH];

  // ---------------------------------------------------------------------------
  // Aligned row register
  // ---------------------------------------------------------------------------
  logic [P_BITWIDTH-1:0] row_q [N_COLS];
  logic                  row_valid_q;

  always_ff @(posedge clk) begin
    if (vd[N_COLS-1]) begin
      row_q <= lane_al;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_valid_q <= 1'b0;
    end else begin
      row_valid_q <= vd[N_COLS-1];
    end
  end

  // ---------------------------------------------------------------------------
  // Requantization: round half toward +inf, then saturate to the A range.
  // One guard bit on the add keeps the rounding increment from wrapping.
  // ---------------------------------------------------------------------------
  logic [RowW-1:0]              q_row;
  logic signed [P_BITWIDTH:0]   rnd;
  logic signed [P_BITWIDTH:0]   ext;
  logic signed [P_BITWIDTH:0]   shv;

  always_comb begin
    q_row       = '0;
    rnd         = '0;
    rnd[Sh-1]   = 1'b1;
    ext         = '0;
    shv         = '0;
    for (int j = 0; j < N_COLS; j++) begin
      ext = $signed({row_q[j][P_BITWIDTH-1], row_q[j]}) + rnd;
      shv = ext >>> Sh;
      if (!shv[P_BITWIDTH] && (|shv[P_BITWIDTH-1:A_BITWIDTH-1])) begin
        q_row[j*A_BITWIDTH +: A_BITWIDTH] = {1'b0, {(A_BITWIDTH-1){1'b1}}};
      end else if (shv[P_BITWIDTH] && !(&shv[P_BITWIDTH-1:A_BITWIDTH-1])) begin
        q_row[j*A_BITWIDTH +: A_BITWIDTH] = {1'b1, {(A_BITWIDTH-1){1'b0}}};
      end else begin
        q_row[j*A_BITWIDTH +: A_BITWIDTH] = shv[A_BITWIDTH-1:0];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output FIFO; occupancy count separates full from empty.
  // ---------------------------------------------------------------------------
  logic [RowW-1:0] mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            ovf_q, ovf_d;
  logic            full, rd_en, wr_en, drop;

  always_comb begin
    full     = (cnt_q == CntW'(FIFO_DEPTH));
    rd_en    = (cnt_q != '0) && out_ready;
    // A full FIFO still takes the row when the head leaves in the same cycle.
    wr_en    = row_valid_q && (!full || rd_en);
    drop     = row_valid_q && full && !rd_en;
    wr_ptr_d = wr_en ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d = rd_en ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    cnt_d    = cnt_q + CntW'(wr_en) - CntW'(rd_en);
    if (drop) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= q_row;
    end
  end

  assign out_valid  = (cnt_q != '0);
  assign out_data   = out_valid ? mem_q[rd_ptr_q] : '0;
  assign fifo_count = cnt_q;
  assign ovf        = ovf_q;

endmodule
